dp_ram_writer: RTL and testbench

Write-side sequencer placed directly upstream of the 8-entry dual-port byte RAM, in the write clock domain. Accepts a valid/ready byte stream, packs it into blocks of up to 8 bytes at RAM addresses 0..7, and drives the RAM write port (`w_en`/`w_addr`/`w_data`). After each block it raises a done pulse and stalls the stream until the read side releases the buffer with `blk_ack`, so the RAM is never overwritten while being read.

---
 rtl/dp_ram_pkg.sv | 13 +
 rtl/dp_ram_writer.sv | 88 ++++++++
 tb/tb_dp_ram_writer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dp_ram_pkg.sv
// Shared constants and FSM encoding for the 8-entry dual-port byte RAM and its write/read sequencers.
package dp_ram_pkg;

  localparam int DP_RAM_DEPTH  = 8;
  localparam int DP_RAM_DATA_W = 8;
  localparam int DP_RAM_ADDR_W = 4;

  typedef enum logic [0:0] {
    FILL     = 1'b0,
    WAIT_ACK = 1'b1
  } wr_state_e;

endpackage

// File: rtl/dp_ram_writer.sv
// Write-side sequencer: packs a valid/ready byte stream into RAM blocks of up to DEPTH bytes,
// then holds off the stream until the read side releases the buffer.
module dp_ram_writer
  import dp_ram_pkg::*;
#(
  parameter int DATA_W = DP_RAM_DATA_W,
  parameter int ADDR_W = DP_RAM_ADDR_W,
  parameter int DEPTH  = DP_RAM_DEPTH
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              blk_ack,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              blk_done,
  output logic [ADDR_W-1:0] blk_len,
  output logic [7:0]        blk_cnt
);

  wr_state_e         r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_w_en;
  logic [ADDR_W-1:0] r_w_addr;
  logic [DATA_W-1:0] r_w_data;
  logic              r_blk_done;
  logic [ADDR_W-1:0] r_blk_len;
  logic [7:0]        r_blk_cnt;

  logic w_accept;
  logic w_blk_end;

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign s_ready   = (r_state == FILL) && !w_rst;
  assign w_accept  = s_valid && s_ready;
  assign w_blk_end = s_last || (r_wr_ptr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state    <= FILL;
      r_wr_ptr   <= '0;
      r_w_en     <= 1'b0;
      r_w_addr   <= '0;
      r_w_data   <= '0;
      r_blk_done <= 1'b0;
      r_blk_len  <= '0;
      r_blk_cnt  <= '0;
    end else begin
      r_w_en     <= 1'b0;
      r_blk_done <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_w_en   <= 1'b1;
            r_w_addr <= r_wr_ptr;
            r_w_data <= s_data;
            if (w_blk_end) begin
              r_blk_done <= 1'b1;
              r_blk_len  <= r_wr_ptr + ADDR_W'(1);
              r_blk_cnt  <= r_blk_cnt + 8'd1;
              r_wr_ptr   <= '0;
              r_state    <= WAIT_ACK;
            end else begin
              r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
          end
        end
        WAIT_ACK: begin
          // Ack is sampled only here, so a level held through FILL cannot skip the wait.
          if (blk_ack) r_state <= FILL;
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign w_en     = r_w_en;
  assign w_addr   = r_w_addr;
  assign w_data   = r_w_data;
  assign blk_done = r_blk_done;
  assign blk_len  = r_blk_len;
  assign blk_cnt  = r_blk_cnt;

endmodule

// File: tb/tb_dp_ram_writer.sv
// Directed test-plan sequences plus random traffic, checked cycle by cycle against a block-level model.
module tb_dp_ram_writer;

  logic       w_clk = 1'b0;
  logic       w_rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       blk_ack;
  logic       w_en;
  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic       blk_done;
  logic [3:0] blk_len;
  logic [7:0] blk_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  dp_ram_writer dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .blk_ack(blk_ack),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .blk_done(blk_done), .blk_len(blk_len), .blk_cnt(blk_cnt)
  );

  always #5 w_clk = ~w_clk;

  // Reference model: block fill level, whether the buffer is owned by the reader,
  // and the outputs the DUT owes in the coming cycle.
  bit       m_held;
  int       m_fill;
  bit       e_wen, e_done;
  int       e_addr, e_data, e_len, e_cnt;
  int       n_writes, n_dones;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_held = 0; m_fill = 0;
    e_wen = 0; e_done = 0; e_addr = 0; e_data = 0; e_len = 0; e_cnt = 0;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model, cross the edge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit a, input bit r);
    bit exp_ready;
    s_valid = v; s_data = d; s_last = l; blk_ack = a; w_rst = r;
    @(negedge w_clk);
    exp_ready = !m_held && !r;
    chk("s_ready", s_ready, exp_ready);
    chk("w_en", w_en, e_wen);
    chk("w_addr", w_addr, e_addr);
    chk("w_data", w_data, e_data);
    chk("blk_done", blk_done, e_done);
    chk("blk_len", blk_len, e_len);
    chk("blk_cnt", blk_cnt, e_cnt);
    if (w_en === 1'b1) n_writes++;
    if (blk_done === 1'b1) n_dones++;
    if (r) begin
      model_reset();
    end else begin
      e_wen = 0; e_done = 0;
      if (m_held) begin
        if (a) m_held = 0;
      end else if (v) begin
        e_wen = 1; e_addr = m_fill; e_data = d;
        m_fill++;
        if (l || m_fill == 8) begin
          e_done = 1; e_len = m_fill; e_cnt = (e_cnt + 1) % 256;
          m_fill = 0; m_held = 1;
        end
      end
    end
    @(posedge w_clk); #1;
  endtask

  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, a, 0);
  endtask

  initial begin
    s_valid = 0; s_data = 0; s_last = 0; blk_ack = 0; w_rst = 1;
    @(posedge w_clk); #1;
    model_reset();
    cyc(0, 0, 0, 0, 1);
    idle(1, 0);

    // Full block 0x10..0x17, then stall until ack
    for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0);
    idle(3, 0);
    idle(1, 1);
    idle(1, 0);

    // Short block with s_last, then a byte that must land at address 0
    cyc(1, 8'hA0, 0, 0, 0); cyc(1, 8'hA1, 0, 0, 0); cyc(1, 8'hA2, 1, 0, 0);
    idle(1, 0);
    idle(1, 1);
    cyc(1, 8'hB0, 1, 0, 0);

    // 0x55 presented through the wait, then ack while still valid
    for (int i = 0; i < 5; i++) cyc(1, 8'h55, 0, 0, 0);
    cyc(1, 8'h55, 0, 1, 0);
    cyc(1, 8'h55, 1, 0, 0);
    idle(1, 0);
    idle(1, 1);

    // Toggled valid across 8 bytes: one completion, contiguous addresses
    n_writes = 0; n_dones = 0;
    for (int i = 0; i < 16; i++) cyc(i % 2 == 0, 8'h60 + 8'(i), 0, 0, 0);
    idle(1, 0);
    chk("toggle_writes", 32'(n_writes), 32'd8);
    chk("toggle_dones", 32'(n_dones), 32'd1);
    idle(1, 1);

    // Reset mid-block discards the partial block
    n_dones = 0;
    for (int i = 0; i < 4; i++) cyc(1, 8'h70 + 8'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 8'h99, 0, 0, 0);
    idle(1, 0);
    chk("rst_no_done", 32'(n_dones), 32'd0);
    cyc(1, 8'h9A, 1, 0, 0);
    idle(1, 1);

    // Ack held high through FILL for two consecutive blocks
    for (int i = 0; i < 20; i++) cyc(1, 8'hC0 + 8'(i), 0, 1, 0);
    chk("ack_held_cnt", 32'(blk_cnt), 32'(e_cnt));

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
